sr_pulse_driver: RTL and testbench

SR_PULSE_DRIVER -- requirements
Module: sr_pulse_driver

---
 rtl/sr_pkg.sv | 19 +
 rtl/sr_pulse_driver_if.sv | 21 ++
 rtl/sr_cycle_timer.sv | 27 ++
 rtl/sr_pulse_driver.sv | 132 +++++++++++++
 tb/tb_sr_pulse_driver.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sr_pkg.sv
// sr_pkg: shared types and constants for the SR latch pulse driver.
// Holds the FSM state enum, counter width and the timer load helper.
package sr_pkg;

   localparam int SR_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE,
      PULSE,
      GUARD,
      CHECK
   } sr_drv_state_t;

   // A phase of n cycles loads n-1 so the last cycle sees the count at zero.
   function automatic logic [SR_CNT_W-1:0] cnt_load(input int n);
      return (n > 0) ? SR_CNT_W'(n - 1) : '0;
   endfunction

endpackage

// File: rtl/sr_pulse_driver_if.sv
// sr_pulse_driver_if: write-request handshake into the pulse driver.
// Signals: req_valid, req_val (1 = set, 0 = reset), req_ready.
interface sr_pulse_driver_if;

   logic req_valid;
   logic req_val;
   logic req_ready;

   modport master (
      output req_valid,
      output req_val,
      input  req_ready
   );

   modport slave (
      input  req_valid,
      input  req_val,
      output req_ready
   );

endinterface

// File: rtl/sr_cycle_timer.sv
// sr_cycle_timer: loadable 8-bit down-counter that stops at zero.
// Ports: clk, rst_n, load, load_val, done (count is zero).
module sr_cycle_timer
   import sr_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                load,
   input  logic [SR_CNT_W-1:0] load_val,
   output logic                done
);

   logic [SR_CNT_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/sr_pulse_driver.sv
// sr_pulse_driver: drives exclusive S/R pulses into a NOR SR latch.
// Ports: clk, rst_n, req (slave handshake), S, R, Q, Qnot, busy,
// fault, fault_clr. Define SR_DRV_READBACK_EN for the readback
// CHECK phase and the sticky fault flag; otherwise GUARD -> IDLE.
module sr_pulse_driver
   import sr_pkg::*;
#(
   parameter int PULSE_CYCLES = 2,
   parameter int GUARD_CYCLES = 1,
   parameter int CHECK_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   sr_pulse_driver_if.slave req,
   output logic             S,
   output logic             R,
   input  logic             Q,
   input  logic             Qnot,
   output logic             busy,
   output logic             fault,
   input  logic             fault_clr
);

`ifdef SR_DRV_READBACK_EN
   localparam sr_drv_state_t POST_GUARD = CHECK;
`else
   localparam sr_drv_state_t POST_GUARD = IDLE;
`endif

   localparam sr_drv_state_t POST_PULSE =
      (GUARD_CYCLES != 0) ? GUARD : POST_GUARD;

   sr_drv_state_t       state;
   sr_drv_state_t       nxt;
   logic                val_q;
   logic                hs;
   logic                nxt_val;
   logic                done;
   logic                tmr_load;
   logic [SR_CNT_W-1:0] tmr_val;
   logic                set_fault;

`ifdef SR_DRV_READBACK_EN
   logic match;
   // Q == Qnot can never satisfy both terms, so it counts as a mismatch.
   assign match = (Q == val_q) && (Qnot == ~val_q);
`else
   logic unused_rb;
   assign unused_rb = ^{Q, Qnot, fault_clr};
`endif

   assign hs      = req.req_valid & req.req_ready;
   assign nxt_val = hs ? req.req_val : val_q;

   always_comb begin
      nxt       = state;
      set_fault = 1'b0;
      unique case (state)
         IDLE:  if (hs) nxt = PULSE;
         PULSE: if (done) nxt = POST_PULSE;
         GUARD: if (done) nxt = POST_GUARD;
         CHECK: begin
`ifdef SR_DRV_READBACK_EN
            if (match) begin
               nxt = IDLE;
            end else if (done) begin
               nxt       = IDLE;
               set_fault = 1'b1;
            end
`else
            nxt = IDLE;
`endif
         end
         default: nxt = IDLE;
      endcase
   end

   // Every state entry restarts the timer at the phase length minus one.
   assign tmr_load = (nxt != state);

   always_comb begin
      tmr_val = '0;
      unique case (nxt)
         PULSE:   tmr_val = cnt_load(PULSE_CYCLES);
         GUARD:   tmr_val = cnt_load(GUARD_CYCLES);
         CHECK:   tmr_val = cnt_load(CHECK_CYCLES);
         default: tmr_val = '0;
      endcase
   end

   sr_cycle_timer u_tmr (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (tmr_load),
      .load_val (tmr_val),
      .done     (done)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         val_q         <= 1'b0;
         S             <= 1'b0;
         R             <= 1'b0;
         busy          <= 1'b0;
         req.req_ready <= 1'b0;
      end else begin
         state         <= nxt;
         if (hs) val_q <= req.req_val;
         S             <= (nxt == PULSE) &  nxt_val;
         R             <= (nxt == PULSE) & ~nxt_val;
         busy          <= (nxt != IDLE);
         req.req_ready <= (nxt == IDLE);
      end
   end

`ifdef SR_DRV_READBACK_EN
   // A new mismatch outranks a coincident clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fault <= 1'b0;
      end else if (set_fault) begin
         fault <= 1'b1;
      end else if (fault_clr) begin
         fault <= 1'b0;
      end
   end
`else
   assign fault = 1'b0;
`endif

endmodule

// File: tb/tb_sr_pulse_driver.sv
// tb_sr_pulse_driver: randomized bench with a transaction-level model
// of the pulse driver plus a second 1-cycle / no-guard instance.
module tb_sr_pulse_driver;

   localparam int P = 2;
   localparam int G = 1;
   localparam int C = 4;

   typedef struct packed {
      logic s;
      logic r;
      logic busy;
      logic ready;
      logic set_f;
   } exp_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic rst2_n = 1'b0;
   always #5 clk = ~clk;

   logic S, R, Q, Qnot, busy, fault;
   logic fault_clr = 1'b0;
   logic S2, R2, Q2, Qnot2, busy2, fault2;

   sr_pulse_driver_if req_if ();
   sr_pulse_driver_if req2_if ();

   sr_pulse_driver #(
      .PULSE_CYCLES (P),
      .GUARD_CYCLES (G),
      .CHECK_CYCLES (C)
   ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req_if),
      .S         (S),
      .R         (R),
      .Q         (Q),
      .Qnot      (Qnot),
      .busy      (busy),
      .fault     (fault),
      .fault_clr (fault_clr)
   );

   sr_pulse_driver #(
      .PULSE_CYCLES (1),
      .GUARD_CYCLES (0),
      .CHECK_CYCLES (C)
   ) u_dut2 (
      .clk       (clk),
      .rst_n     (rst2_n),
      .req       (req2_if),
      .S         (S2),
      .R         (R2),
      .Q         (Q2),
      .Qnot      (Qnot2),
      .busy      (busy2),
      .fault     (fault2),
      .fault_clr (1'b0)
   );

   int passed = 0;
   int total  = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
   endtask

   // Latch models: mode 0 healthy, 1 stuck Q=0, 2 stuck Q=Qnot=1.
   int   mode = 0;
   logic q_lat = 1'b0;
   logic q2_lat = 1'b0;

   always @(negedge clk) begin
      if (S) q_lat <= 1'b1;
      else if (R) q_lat <= 1'b0;
      if (S2) q2_lat <= 1'b1;
      else if (R2) q2_lat <= 1'b0;
   end

   assign Q     = (mode == 0) ? q_lat  : (mode == 2);
   assign Qnot  = (mode == 0) ? ~q_lat : 1'b1;
   assign Q2    = q2_lat;
   assign Qnot2 = ~q2_lat;

   // Expected per-cycle outputs of one accepted request.
   exp_t exq[$];
   logic exp_fault = 1'b0;

   task automatic schedule(input logic v);
      bit agree;
      for (int i = 0; i < P; i++) exq.push_back('{v, ~v, 1'b1, 1'b0, 1'b0});
      for (int i = 0; i < G; i++) exq.push_back('{0, 0, 1'b1, 1'b0, 1'b0});
`ifdef SR_DRV_READBACK_EN
      agree = (mode == 0) || (mode == 1 && !v);
      if (agree) begin
         exq.push_back('{0, 0, 1'b1, 1'b0, 1'b0});
      end else begin
         for (int i = 0; i < C; i++)
            exq.push_back('{0, 0, 1'b1, 1'b0, (i == C - 1)});
      end
`else
      agree = 1'b1;
      if (!agree) $display("unexpected");
`endif
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         exq.delete();
         exp_fault = 1'b0;
         e = '0;
      end else if (exq.size() != 0) begin
         e = exq.pop_front();
      end else begin
         e = '{0, 0, 1'b0, 1'b1, 1'b0};
      end
      chk("S", S, e.s);
      chk("R", R, e.r);
      chk("busy", busy, e.busy);
      chk("req_ready", req_if.req_ready, e.ready);
      chk("fault", fault, exp_fault);
      chk("S_and_R", S & R, 0);
      if (rst_n) begin
         if (e.set_f) exp_fault = 1'b1;
         else if (fault_clr) exp_fault = 1'b0;
         if (e.ready && req_if.req_valid) schedule(req_if.req_val);
      end
   end

   // Second instance: S/R exclusive and every pulse exactly one cycle.
   int s_run = 0;
   int r_run = 0;
   int npulse2 = 0;
   bit done2 = 0;

   always @(negedge clk) begin
      if (rst2_n) begin
         chk("dut2_S_and_R", S2 & R2, 0);
         if (S2) s_run++;
         else if (s_run != 0) begin
            chk("dut2_S_width", s_run, 1);
            s_run = 0;
            npulse2++;
         end
         if (R2) r_run++;
         else if (r_run != 0) begin
            chk("dut2_R_width", r_run, 1);
            r_run = 0;
            npulse2++;
         end
      end
   end

   initial begin
      req2_if.req_valid = 1'b0;
      req2_if.req_val   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1 rst2_n = 1'b1;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk);
         #1;
         req2_if.req_valid = 1'b1;
         req2_if.req_val   = ~req2_if.req_val;
      end
      @(posedge clk);
      #1 req2_if.req_valid = 1'b0;
      repeat (4) @(posedge clk);
      done2 = 1;
   end

   task automatic quiet(input int n);
      @(posedge clk);
      #1;
      req_if.req_valid = 1'b0;
      fault_clr        = 1'b0;
      repeat (n) @(posedge clk);
   endtask

   task automatic issue(input logic v, input int hold);
      @(posedge clk);
      #1;
      req_if.req_valid = 1'b1;
      req_if.req_val   = v;
      repeat (hold) @(posedge clk);
      #1 req_if.req_valid = 1'b0;
   endtask

   task automatic rand_phase(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         req_if.req_valid = ($urandom_range(0, 2) == 0);
         req_if.req_val   = $urandom_range(0, 1);
         fault_clr        = ($urandom_range(0, 7) == 0);
      end
      quiet(20);
   endtask

   initial begin
      req_if.req_valid = 1'b0;
      req_if.req_val   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1 rst_n = 1'b1;

      issue(1'b1, 1);
      quiet(10);
      issue(1'b0, 2);
      quiet(10);
      mode = 1;
      issue(1'b1, 1);
      quiet(12);
      fault_clr = 1'b1;
      quiet(4);
      mode = 0;

      rand_phase(300);
      mode = 1;
      rand_phase(150);
      mode = 2;
      rand_phase(100);
      mode = 0;
      rand_phase(100);

      issue(1'b1, 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_async_S", S, 0);
      chk("rst_async_R", R, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", req_if.req_ready, 0);
      chk("rst_fault", fault, 0);
      @(negedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk);
      #1 chk("ready_after_rst", req_if.req_ready, 1);
      quiet(10);

      for (int i = 0; i < 1000 && !done2; i++) @(posedge clk);
      chk("dut2_finished", done2, 1);
      chk("dut2_pulses", (npulse2 >= 20), 1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
